fetch_queue: RTL and testbench
==============================

# fetch_queue

Packet buffer between the instruction-fetch front-end and the 4-wide decoder stage. It accepts fetch packets from the front-end: up to 4 instructions, a slot-valid mask, start PC and branch-prediction fields. It presents the oldest packet to the decoder with a valid/ready handshake. When the decoder reports a misprediction on the presented packet, the queue repairs that packet's prediction fields, discards all younger wrong-path packets and issues a one-cycle redirect to the front-end.

## Interface
- `DEPTH`, 4: packet entries; power of two, ≥2.
- `clk` input 1: sole clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush` input 1: backend flush; empties the queue; synchronous.
- `in_valid` input 1: front-end packet valid.
- `in_ready` output 1: queue can accept a packet.
- `in_instr[0..3]` input 4×32: fetched instructions.
- `in_fetch_valid` input 4: slot valid mask; contiguous from bit 0.
- `in_start_pc` input 32: PC of slot 0.
- `in_pred_taken` input 1: predicted taken.
- `in_pred_cut_pos` input 2: predicted branch slot index.
- `in_pred_next_pc` input 32: predicted next fetch PC.
- `ifu_valid` output 1: head packet presented to the decoder.
- `instr_0..instr_3` output 32 each: head instructions.
- `fetch_valid` output 4: head slot mask.
- `start_pc` output 32: head start PC.
- `pred_taken`, `pred_cut_pos`, `pred_next_fetch_target_pc` outputs 1/2/32: head prediction fields.
- `decoder_ready` input 1: decoder accepts this cycle.
- `pred_wrong` input 1: decoder flags the head as mispredicted (combinational in the decoder).
- `real_branch_valid` input 1: a taken-type branch exists in the head.
- `real_cut_pos` input 2: slot index (0..3) of that branch.
- `real_jump_target_pc` input 32: resolved branch target.
- `redirect_valid` output 1: one-cycle redirect pulse to the PC generator.
- `redirect_pc` output 32: corrected next fetch PC.

## Operation
- Circular buffer with head/tail pointers and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue when `in_valid && in_ready`. `in_ready = (count != DEPTH) && state == RUN && !flush`.
- `ifu_valid = (count != 0)`. All packet outputs are driven from the head entry. When the queue is empty, packet outputs are 0.
- Dequeue when `ifu_valid && decoder_ready && !pred_wrong`.
- Enqueue and dequeue in the same cycle are allowed. When full, a simultaneous dequeue does not raise `in_ready` in that cycle.
- FSM:
  - RUN → REDIRECT when `ifu_valid && pred_wrong && !flush`.
  - REDIRECT → RUN unconditionally after one cycle.
- Correction, applied in the RUN cycle where `pred_wrong` is seen:
  - Set count to 1 and tail to head+1. Younger packets are dropped, and any same-cycle enqueue is discarded.
  - If `real_branch_valid`: head `pred_taken=1`, `pred_cut_pos=real_cut_pos`, `pred_next_pc=real_jump_target_pc`, and slots above `real_cut_pos` are cleared in `fetch_valid`.
  - Otherwise: `pred_taken=0`, `pred_cut_pos=0`, `pred_next_pc = start_pc + 4*popcount(fetch_valid)` (32-bit wrap).
  - Latch the corrected `pred_next_pc` into `redirect_pc`.
- REDIRECT state:
  - `redirect_valid=1` and `in_ready=0`.
  - The corrected head is presented and may dequeue.
  - `pred_wrong` is ignored in this state.
- After observing `redirect_valid`, the front-end sends only corrected-path packets.
- `flush` has priority over everything. It clears count and pointers, returns the FSM to RUN, and forces `redirect_valid=0`. No redirect is issued for a pending correction.

## Timing
- Reset values:
  - `in_ready=0` during reset and 1 on the first cycle after.
  - All other outputs 0.
  - State RUN, count 0.
- Enqueue-to-present latency is 1 cycle. There is no bypass: a packet written in cycle N appears on `ifu_valid` in cycle N+1.
- Throughput is 1 packet per cycle sustained.
- Redirect timing:
  - `pred_wrong` in cycle N gives `redirect_valid` in cycle N+1, held for exactly 1 cycle.
  - The corrected head is visible from cycle N+1.
- `flush` or reset asserted in cycle N clears the queue; the result is visible in N+1.
- Storage holds its contents through reset; only control state is cleared.

## Structure
- Shared package (alongside `mycpu.h` types) holds `fetch_packet_t` {instr[4], fetch_valid, start_pc, pred_taken, pred_cut_pos, pred_next_pc} and the `FQ_RUN`/`FQ_REDIRECT` state encoding.
- Sub-module `fq_pred_fix` (combinational) computes the corrected packet and redirect PC from the head and the decoder resolution inputs.
- Top level holds the storage array, pointers, count and FSM.

## Test plan
- Fill/drain: DEPTH=4, enqueue 5 packets with `decoder_ready=0` → `in_ready` drops after the 4th. Then set `decoder_ready=1` → packets leave in order (start_pc 0x1c000000, +0x10, …), one per cycle.
- Taken fix: head `start_pc=0x1c000000`, `pred_taken=1`, `cut_pos=3`, `next=0x1c000100`; decoder returns `real_branch_valid=1`, `real_cut_pos=1`, `target=0x1c000040` → next cycle `redirect_valid=1`, `redirect_pc=0x1c000040`, head `fetch_valid=4'b0011`, `cut_pos=1`, `count=1`.
- False-taken fix: head `pred_taken=1`, no branch, `fetch_valid=4'b0111`, `start_pc=0x1c000008` → `pred_taken=0`, `redirect_pc=0x1c000014`.
- Simultaneous events: `pred_wrong` with `in_valid=1` and 2 younger entries → the incoming packet and both younger entries are dropped; count is 1 in the next cycle.
- Flush priority: `flush` together with `pred_wrong` → no `redirect_valid`, `ifu_valid=0` and `in_ready=1` in the next cycle.
- Mid-operation reset: `rst_n=0` for 1 cycle with 3 entries and the FSM in REDIRECT → every output is 0 in the next cycle, state RUN.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue types: packed fetch packet, FSM encoding and a slot popcount.
// Combinational helpers only; no latency and no flow control here.
package fetch_queue_pkg;

   typedef struct packed {
      logic [3:0][31:0] instr;
      logic [3:0]       fetch_valid;
      logic [31:0]      start_pc;
      logic             pred_taken;
      logic [1:0]       pred_cut_pos;
      logic [31:0]      pred_next_pc;
   } fetch_packet_t;

   typedef enum logic {
      FQ_RUN      = 1'b0,
      FQ_REDIRECT = 1'b1
   } fq_state_e;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         cnt = cnt + 3'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fq_pred_fix.sv
// Repairs the head packet's prediction from the decoder's branch resolution; combinational.
// Zero latency; no flow control, the caller decides when the result is written back.
module fq_pred_fix
   import fetch_queue_pkg::*;
(
   input  fetch_packet_t head,
   input  logic          real_branch_valid,
   input  logic [1:0]    real_cut_pos,
   input  logic [31:0]   real_jump_target_pc,
   output fetch_packet_t fixed,
   output logic [31:0]   redirect_pc
);

   logic [3:0] keep_mask;

   always_comb begin
      keep_mask = 4'b1111;
      case (real_cut_pos)
         2'd0:    keep_mask = 4'b0001;
         2'd1:    keep_mask = 4'b0011;
         2'd2:    keep_mask = 4'b0111;
         default: keep_mask = 4'b1111;
      endcase

      fixed = head;
      if (real_branch_valid) begin
         // Slots past the taken branch are wrong-path and must not reach decode.
         fixed.pred_taken   = 1'b1;
         fixed.pred_cut_pos = real_cut_pos;
         fixed.pred_next_pc = real_jump_target_pc;
         fixed.fetch_valid  = head.fetch_valid & keep_mask;
      end else begin
         fixed.pred_taken   = 1'b0;
         fixed.pred_cut_pos = 2'd0;
         fixed.pred_next_pc = head.start_pc + 32'({popcount4(head.fetch_valid), 2'b00});
      end
      redirect_pc = fixed.pred_next_pc;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch packet queue between front-end and decoder with misprediction repair and redirect.
// Enqueue-to-present 1 cycle, no bypass; in_ready drops when full or while redirecting.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0][31:0] in_instr,
   input  logic [3:0]       in_fetch_valid,
   input  logic [31:0]      in_start_pc,
   input  logic             in_pred_taken,
   input  logic [1:0]       in_pred_cut_pos,
   input  logic [31:0]      in_pred_next_pc,
   output logic             ifu_valid,
   output logic [31:0]      instr_0,
   output logic [31:0]      instr_1,
   output logic [31:0]      instr_2,
   output logic [31:0]      instr_3,
   output logic [3:0]       fetch_valid,
   output logic [31:0]      start_pc,
   output logic             pred_taken,
   output logic [1:0]       pred_cut_pos,
   output logic [31:0]      pred_next_fetch_target_pc,
   input  logic             decoder_ready,
   input  logic             pred_wrong,
   input  logic             real_branch_valid,
   input  logic [1:0]       real_cut_pos,
   input  logic [31:0]      real_jump_target_pc,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_packet_t mem [DEPTH];
   fetch_packet_t in_pkt, head_pkt, out_pkt, fixed_pkt;
   logic [PW-1:0] head_ptr, tail_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fix_pc;
   fq_state_e     state, state_nxt;
   logic          enq, deq, do_fix;

   assign in_pkt = '{instr:        in_instr,
                     fetch_valid:  in_fetch_valid,
                     start_pc:     in_start_pc,
                     pred_taken:   in_pred_taken,
                     pred_cut_pos: in_pred_cut_pos,
                     pred_next_pc: in_pred_next_pc};

   assign ifu_valid = (count != '0);
   assign head_pkt  = mem[head_ptr];
   assign out_pkt   = ifu_valid ? head_pkt : '0;

   assign instr_0                   = out_pkt.instr[0];
   assign instr_1                   = out_pkt.instr[1];
   assign instr_2                   = out_pkt.instr[2];
   assign instr_3                   = out_pkt.instr[3];
   assign fetch_valid               = out_pkt.fetch_valid;
   assign start_pc                  = out_pkt.start_pc;
   assign pred_taken                = out_pkt.pred_taken;
   assign pred_cut_pos              = out_pkt.pred_cut_pos;
   assign pred_next_fetch_target_pc = out_pkt.pred_next_pc;

   fq_pred_fix u_pred_fix (
      .head                (head_pkt),
      .real_branch_valid   (real_branch_valid),
      .real_cut_pos        (real_cut_pos),
      .real_jump_target_pc (real_jump_target_pc),
      .fixed               (fixed_pkt),
      .redirect_pc         (fix_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FQ_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      in_ready       = 1'b0;
      redirect_valid = 1'b0;
      do_fix         = 1'b0;
      deq            = 1'b0;
      case (state)
         FQ_RUN: begin
            in_ready = rst_n && (count != CW'(DEPTH)) && !flush;
            do_fix   = rst_n && ifu_valid && pred_wrong && !flush;
            deq      = ifu_valid && decoder_ready && !pred_wrong;
            if (do_fix) begin
               state_nxt = FQ_REDIRECT;
            end
         end
         FQ_REDIRECT: begin
            // The decoder's pred_wrong is stale here; the head was already repaired.
            redirect_valid = !flush;
            deq            = ifu_valid && decoder_ready;
            state_nxt      = FQ_RUN;
         end
         default: state_nxt = FQ_RUN;
      endcase
      if (flush) begin
         state_nxt = FQ_RUN;
      end
   end

   assign enq = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_ptr    <= '0;
         tail_ptr    <= '0;
         count       <= '0;
         redirect_pc <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (do_fix) begin
         // Only the head survives; any same-cycle enqueue is wrong-path.
         tail_ptr    <= head_ptr + PW'(1);
         count       <= CW'(1);
         redirect_pc <= fix_pc;
      end else begin
         if (enq) begin
            tail_ptr <= tail_ptr + PW'(1);
         end
         if (deq) begin
            head_ptr <= head_ptr + PW'(1);
         end
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_fix) begin
         mem[head_ptr] <= fixed_pkt;
      end else if (enq) begin
         mem[tail_ptr] <= in_pkt;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: fill/drain, prediction repair, flush and reset.
// Samples outputs 2 time units after each rising edge; one packet per cycle when accepted.
// Drives in_valid only while testing acceptance; decoder_ready toggled to exercise stalls.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][31:0] in_instr;
    logic [3:0]       in_fetch_valid;
    logic [31:0]      in_start_pc;
    logic             in_pred_taken;
    logic [1:0]       in_pred_cut_pos;
    logic [31:0]      in_pred_next_pc;
    logic             ifu_valid;
    logic [31:0]      instr_0, instr_1, instr_2, instr_3;
    logic [3:0]       fetch_valid;
    logic [31:0]      start_pc;
    logic             pred_taken;
    logic [1:0]       pred_cut_pos;
    logic [31:0]      pred_next_fetch_target_pc;
    logic             decoder_ready;
    logic             pred_wrong;
    logic             real_branch_valid;
    logic [1:0]       real_cut_pos;
    logic [31:0]      real_jump_target_pc;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BASE = 32'h1c00_0000;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .flush                     (flush),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_instr                  (in_instr),
        .in_fetch_valid            (in_fetch_valid),
        .in_start_pc               (in_start_pc),
        .in_pred_taken             (in_pred_taken),
        .in_pred_cut_pos           (in_pred_cut_pos),
        .in_pred_next_pc           (in_pred_next_pc),
        .ifu_valid                 (ifu_valid),
        .instr_0                   (instr_0),
        .instr_1                   (instr_1),
        .instr_2                   (instr_2),
        .instr_3                   (instr_3),
        .fetch_valid               (fetch_valid),
        .start_pc                  (start_pc),
        .pred_taken                (pred_taken),
        .pred_cut_pos              (pred_cut_pos),
        .pred_next_fetch_target_pc (pred_next_fetch_target_pc),
        .decoder_ready             (decoder_ready),
        .pred_wrong                (pred_wrong),
        .real_branch_valid         (real_branch_valid),
        .real_cut_pos              (real_cut_pos),
        .real_jump_target_pc       (real_jump_target_pc),
        .redirect_valid            (redirect_valid),
        .redirect_pc               (redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pkt(input logic [31:0] pc, input logic [3:0] fv, input logic pt,
                             input logic [1:0] cut, input logic [31:0] nxt);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr[k] = pc + 32'(k);
        end
        in_fetch_valid  = fv;
        in_start_pc     = pc;
        in_pred_taken   = pt;
        in_pred_cut_pos = cut;
        in_pred_next_pc = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid            = 1'b0;
        pred_wrong          = 1'b0;
        flush               = 1'b0;
        real_branch_valid   = 1'b0;
        real_cut_pos        = 2'd0;
        real_jump_target_pc = 32'd0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        decoder_ready = 1'b0;
        in_instr = '0;
        in_fetch_valid = '0;
        in_start_pc = '0;
        in_pred_taken = 1'b0;
        in_pred_cut_pos = '0;
        in_pred_next_pc = '0;
        tick();
        tick();
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_ifu_valid", ifu_valid, 1'b0);
        chk("reset_redirect_valid", redirect_valid, 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            drive_pkt(BASE + 32'(16 * i), 4'hF, 1'b0, 2'd0, BASE + 32'(16 * i + 16));
            #1;
            chk("fill_in_ready", in_ready, (i < 4) ? 1'b1 : 1'b0);
            if (i == 0) begin
                chk("no_bypass_ifu_valid", ifu_valid, 1'b0);
            end
            tick();
            if (i == 0) begin
                chk("latency1_ifu_valid", ifu_valid, 1'b1);
            end
        end
        chk("full_count", dut.count, 3'd4);
        decoder_ready = 1'b1;
        #1;
        chk("full_deq_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_start_pc", start_pc, BASE + 32'(16 * k));
            chk("drain_instr_3", instr_3, BASE + 32'(16 * k + 3));
            tick();
        end
        chk("drain_empty", ifu_valid, 1'b0);
        chk("drain_empty_pc", start_pc, 32'h0);
        decoder_ready = 1'b0;

        drive_pkt(BASE, 4'hF, 1'b1, 2'd3, 32'h1c00_0100);
        tick();
        pred_wrong = 1'b1;
        real_branch_valid = 1'b1;
        real_cut_pos = 2'd1;
        real_jump_target_pc = 32'h1c00_0040;
        tick();
        chk("taken_redirect_valid", redirect_valid, 1'b1);
        chk("taken_redirect_pc", redirect_pc, 32'h1c00_0040);
        chk("taken_fetch_valid", fetch_valid, 4'b0011);
        chk("taken_cut_pos", pred_cut_pos, 2'd1);
        chk("taken_pred_taken", pred_taken, 1'b1);
        chk("taken_next_pc", pred_next_fetch_target_pc, 32'h1c00_0040);
        chk("taken_count", dut.count, 3'd1);
        chk("taken_in_ready", in_ready, 1'b0);
        tick();
        chk("redirect_one_cycle", redirect_valid, 1'b0);
        chk("after_redirect_in_ready", in_ready, 1'b1);
        chk("after_redirect_head", ifu_valid, 1'b1);
        decoder_ready = 1'b1;
        tick();
        decoder_ready = 1'b0;
        chk("taken_drained", ifu_valid, 1'b0);

        drive_pkt(32'h1c00_0008, 4'b0111, 1'b1, 2'd2, 32'h1c00_0200);
        tick();
        pred_wrong = 1'b1;
        tick();
        chk("nt_pred_taken", pred_taken, 1'b0);
        chk("nt_cut_pos", pred_cut_pos, 2'd0);
        chk("nt_redirect_pc", redirect_pc, 32'h1c00_0014);
        chk("nt_next_pc", pred_next_fetch_target_pc, 32'h1c00_0014);
        chk("nt_fetch_valid", fetch_valid, 4'b0111);
        decoder_ready = 1'b1;
        pred_wrong = 1'b1;
        tick();
        decoder_ready = 1'b0;
        chk("redirect_deq_ifu_valid", ifu_valid, 1'b0);
        chk("redirect_deq_redirect_valid", redirect_valid, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drive_pkt(32'h1c00_1000 + 32'(16 * i), 4'hF, 1'b0, 2'd0, 32'h1c00_1010 + 32'(16 * i));
            tick();
        end
        chk("simul_pre_count", dut.count, 3'd3);
        drive_pkt(32'h1c00_3000, 4'hF, 1'b0, 2'd0, 32'h1c00_3010);
        pred_wrong = 1'b1;
        real_branch_valid = 1'b1;
        real_cut_pos = 2'd0;
        real_jump_target_pc = 32'h1c00_2000;
        tick();
        chk("simul_count", dut.count, 3'd1);
        chk("simul_head_pc", start_pc, 32'h1c00_1000);
        chk("simul_fetch_valid", fetch_valid, 4'b0001);
        chk("simul_redirect_pc", redirect_pc, 32'h1c00_2000);
        tick();
        decoder_ready = 1'b1;
        tick();
        decoder_ready = 1'b0;
        chk("simul_dropped", ifu_valid, 1'b0);
        drive_pkt(32'h1c00_4000, 4'hF, 1'b0, 2'd0, 32'h1c00_4010);
        tick();
        chk("simul_next_pkt", start_pc, 32'h1c00_4000);
        decoder_ready = 1'b1;
        tick();
        decoder_ready = 1'b0;

        drive_pkt(32'h1c00_5000, 4'hF, 1'b1, 2'd3, 32'h1c00_6000);
        tick();
        pred_wrong = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_blocks_in_ready", in_ready, 1'b0);
        tick();
        chk("flush_redirect_valid", redirect_valid, 1'b0);
        chk("flush_ifu_valid", ifu_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_state", dut.state, FQ_RUN);

        for (int i = 0; i < 3; i++) begin
            drive_pkt(32'h1c00_7000 + 32'(16 * i), 4'hF, 1'b0, 2'd0, 32'h1c00_7010 + 32'(16 * i));
            tick();
        end
        pred_wrong = 1'b1;
        tick();
        chk("pre_reset_redirect", redirect_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_ifu_valid", ifu_valid, 1'b0);
        chk("mid_reset_instr_0", instr_0, 32'h0);
        chk("mid_reset_start_pc", start_pc, 32'h0);
        chk("mid_reset_fetch_valid", fetch_valid, 4'h0);
        chk("mid_reset_next_pc", pred_next_fetch_target_pc, 32'h0);
        chk("mid_reset_redirect_valid", redirect_valid, 1'b0);
        chk("mid_reset_redirect_pc", redirect_pc, 32'h0);
        chk("mid_reset_in_ready", in_ready, 1'b0);
        chk("mid_reset_state", dut.state, FQ_RUN);
        rst_n = 1'b1;
        #1;
        chk("mid_reset_release_in_ready", in_ready, 1'b1);
        chk("mid_reset_count", dut.count, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
